dm_arbiter: RTL

- Two-master arbiter and access sequencer in front of the single-port word data memory (1024 x 32, word-indexed by addr[11:2], combinational read, write on posedge, synchronous clear on reset).
- Master 0 is the CPU load/store port; master 1 is a secondary agent (debug/DMA loader).
- Shares the memory by round-robin (or fixed priority), runs a 3-state access FSM, rejects misaligned accesses, and returns read data with a one-cycle ack.

---
 rtl/dm_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter and three-state access sequencer in front of
// a single-port word data memory. Master 0 is the CPU load/store port and
// master 1 is a secondary agent. Misaligned accesses are refused without
// touching memory. Every completion is reported with a one-cycle ack.
module dm_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [31:0]       m0_pc,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [31:0]       m1_pc,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [31:0]       m1_rdata,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_WriteData,
  output logic [31:0]       mem_PC,
  input  logic [31:0]       mem_ReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;

  // Latched transaction, owned from the accepting edge until the ack cycle.
  logic              owner_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       pc_r;
  logic [31:0]       rdata_r;
  logic              err_r;
  logic              m0_ack_r;
  logic              m1_ack_r;
  logic              mem_write_r;
  logic              mem_read_r;
  // Master granted most recently; 1 after reset so master 0 wins the first tie.
  logic              last_r;

  logic              any_req_s;
  logic              grant_s;
  logic              sel_we_s;
  logic              sel_mis_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [31:0]       sel_wdata_s;
  logic [31:0]       sel_pc_s;

  // Pick the winner among the current requesters.
  always_comb begin
    any_req_s = m0_req | m1_req;
    grant_s   = 1'b0;
    if (m0_req && m1_req) begin
      if (FIXED_PRIO != 0) begin
        grant_s = 1'b0;
      end else begin
        // Tie: the master that was not granted last takes this slot.
        grant_s = ~last_r;
      end
    end else if (m1_req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Route the winner's request fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = 32'h0000_0000;
    sel_pc_s    = 32'h0000_0000;
    if (grant_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
      sel_pc_s    = m1_pc;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      sel_pc_s    = m0_pc;
    end
    sel_mis_s = (sel_addr_s[1:0] != 2'b00);
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          if (sel_mis_s) begin
            state_s = RESP;
          end else begin
            state_s = ACCESS;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Transaction latch, memory strobes, read capture and completion flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r     <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= 32'h0000_0000;
      pc_r        <= 32'h0000_0000;
      rdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
      m0_ack_r    <= 1'b0;
      m1_ack_r    <= 1'b0;
      mem_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      last_r      <= 1'b1;
    end else begin
      m0_ack_r    <= 1'b0;
      m1_ack_r    <= 1'b0;
      mem_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r <= grant_s;
            we_r    <= sel_we_s;
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
            pc_r    <= sel_pc_s;
            last_r  <= grant_s;
            if (sel_mis_s) begin
              // Refused: go straight to the response with err.
              err_r    <= 1'b1;
              m0_ack_r <= ~grant_s;
              m1_ack_r <= grant_s;
            end else begin
              err_r       <= 1'b0;
              mem_write_r <= sel_we_s;
              mem_read_r  <= ~sel_we_s;
            end
          end
        end
        ACCESS: begin
          // Writes leave rdata untouched so the ack returns the old value.
          if (!we_r) begin
            rdata_r <= mem_ReadData;
          end
          err_r    <= 1'b0;
          m0_ack_r <= ~owner_r;
          m1_ack_r <= owner_r;
        end
        RESP: begin
          err_r <= err_r;
        end
        default: begin
          err_r <= 1'b0;
        end
      endcase
    end
  end

  // Strobes and acks are gated by reset so an aborted access never lands.
  assign mem_MemWrite  = mem_write_r & ~reset;
  assign mem_MemRead   = mem_read_r & ~reset;
  assign mem_addr      = addr_r;
  assign mem_WriteData = wdata_r;
  assign mem_PC        = pc_r;

  assign m0_ack   = m0_ack_r & ~reset;
  assign m1_ack   = m1_ack_r & ~reset;
  assign m0_err   = err_r & m0_ack_r & ~reset;
  assign m1_err   = err_r & m1_ack_r & ~reset;
  assign m0_rdata = rdata_r;
  assign m1_rdata = rdata_r;

endmodule
